// File: rtl/vga_sram_arbiter.sv
// Time-division arbiter for one async SRAM: VGA reads own even slots while the display is active, and queued host ops use the rest.
// VGA sample to valid takes 2 cycles and a host read takes at least 3; oHost_Ready drops only when the in-order host queue is full.
module vga_sram_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iVGA_Active,
    input  logic [ADDR_W-1:0] iVGA_Addr,
    output logic [DATA_W-1:0] oVGA_Data,
    output logic              oVGA_Valid,
    input  logic              iHost_Req,
    input  logic              iHost_We,
    input  logic [ADDR_W-1:0] iHost_Addr,
    input  logic [DATA_W-1:0] iHost_WData,
    output logic              oHost_Ready,
    output logic [DATA_W-1:0] oHost_RData,
    output logic              oHost_RValid,
    output logic [ADDR_W-1:0] oSRAM_Addr,
    output logic [DATA_W-1:0] oSRAM_DQ_Out,
    output logic              oSRAM_DQ_OE,
    input  logic [DATA_W-1:0] iSRAM_DQ_In,
    output logic              oSRAM_CE_N,
    output logic              oSRAM_OE_N,
    output logic              oSRAM_WE_N
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_VGA_RD, S_HOST_RD, S_HOST_WR} acc_t;

    logic              phase_q;
    acc_t              state_q, state_d;
    req_t              fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;
    req_t              head;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_out_q, dq_out_d;
    logic              ce_n_q, oe_n_q, we_n_q, dq_oe_q;
    logic [DATA_W-1:0] vga_data_q, host_rdata_q;
    logic              vga_valid_q, host_rvalid_q;

    // Readiness looks only at the registered count, so a full queue refuses even on a pop edge.
    assign oHost_Ready = (count_q < CW'(FIFO_DEPTH));
    assign push        = iHost_Req & oHost_Ready;
    assign head        = fifo_q[rd_ptr_q];

    always_comb begin
        state_d  = S_IDLE;
        pop      = 1'b0;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        count_d  = count_q;
        if (!phase_q && iVGA_Active) begin
            state_d = S_VGA_RD;
            addr_d  = iVGA_Addr;
        end else if (count_q != '0) begin
            pop    = 1'b1;
            addr_d = head.addr;
            if (head.we) begin
                state_d  = S_HOST_WR;
                dq_out_d = head.wdata;
            end else begin
                state_d = S_HOST_RD;
            end
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{we: iHost_We, addr: iHost_Addr, wdata: iHost_WData};
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            phase_q       <= 1'b0;
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            addr_q        <= '0;
            dq_out_q      <= '0;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            dq_oe_q       <= 1'b0;
            vga_data_q    <= '0;
            vga_valid_q   <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            phase_q  <= ~phase_q;
            state_q  <= state_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            ce_n_q  <= (state_d == S_IDLE);
            oe_n_q  <= !((state_d == S_VGA_RD) || (state_d == S_HOST_RD));
            we_n_q  <= (state_d != S_HOST_WR);
            dq_oe_q <= (state_d == S_HOST_WR);
            // Pad data is captured on the edge that closes the read strobe cycle.
            vga_valid_q   <= (state_q == S_VGA_RD);
            host_rvalid_q <= (state_q == S_HOST_RD);
            if (state_q == S_VGA_RD)  vga_data_q   <= iSRAM_DQ_In;
            if (state_q == S_HOST_RD) host_rdata_q <= iSRAM_DQ_In;
        end
    end

    assign oSRAM_Addr   = addr_q;
    assign oSRAM_DQ_Out = dq_out_q;
    assign oSRAM_DQ_OE  = dq_oe_q;
    assign oSRAM_CE_N   = ce_n_q;
    assign oSRAM_OE_N   = oe_n_q;
    assign oSRAM_WE_N   = we_n_q;
    assign oVGA_Data    = vga_data_q;
    assign oVGA_Valid   = vga_valid_q;
    assign oHost_RData  = host_rdata_q;
    assign oHost_RValid = host_rvalid_q;

endmodule
